// File: rtl/fp_div_seq_issue.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_seq_issue
// Purpose  : Issue/collect controller around a multi-cycle sequential FP
//            divider. Launches one division at a time from a valid/ready
//            operand stream, waits for complete to fall then rise, and
//            buffers results in a 2-entry FIFO presented on a valid/ready
//            result stream with the request tag and a timeout error flag.
// Revision : 1.0 - initial release
// ============================================================================
module fp_div_seq_issue #(
    parameter int SIG_WIDTH = 23,
    parameter int EXP_WIDTH = 8,
    parameter int TAG_WIDTH = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]       in_a,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]       in_b,
    input  logic [2:0]                         in_rnd,
    input  logic [TAG_WIDTH-1:0]               in_tag,
    output logic [SIG_WIDTH+EXP_WIDTH:0]       div_a,
    output logic [SIG_WIDTH+EXP_WIDTH:0]       div_b,
    output logic [2:0]                         div_rnd,
    output logic                               div_start,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]       div_z,
    input  logic [7:0]                         div_status,
    input  logic                               div_complete,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [SIG_WIDTH+EXP_WIDTH:0]       out_z,
    output logic [7:0]                         out_status,
    output logic [TAG_WIDTH-1:0]               out_tag,
    output logic                               out_err,
    output logic [7:0]                         sticky_status,
    input  logic                               clear_sticky
);

    localparam int c_word_w = SIG_WIDTH + EXP_WIDTH + 1;
    localparam int c_ent_w  = c_word_w + 8 + TAG_WIDTH + 1;
    localparam int c_cnt_w  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT_LO = 2'd2,
        S_WAIT_HI = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [1:0]             r_count;
    logic [c_ent_w-1:0]     r_slot0;
    logic [c_ent_w-1:0]     r_slot1;
    logic [c_ent_w-1:0]     w_push_data;
    logic [c_word_w-1:0]    r_div_a;
    logic [c_word_w-1:0]    r_div_b;
    logic [2:0]             r_div_rnd;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [7:0]             r_sticky;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_start;
    logic                   w_timeout;

    // A free FIFO slot at issue time is the credit that guarantees capture.
    assign in_ready  = (r_state == S_IDLE) && (r_count != 2'd2);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_count != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign w_timeout = (r_cnt == c_cnt_w'(TIMEOUT));

    assign div_a         = r_div_a;
    assign div_b         = r_div_b;
    assign div_rnd       = r_div_rnd;
    assign div_start     = w_start;
    assign sticky_status = r_sticky;
    assign {out_z, out_status, out_tag, out_err} = r_slot0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state, launch pulse and FIFO push decode; a real complete wins over
    // a timeout that expires in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_push      = 1'b0;
        w_push_data = {div_z, div_status, r_tag, 1'b0};
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                w_start     = 1'b1;
                w_state_nxt = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (w_timeout) begin
                    w_push      = 1'b1;
                    w_push_data = {{c_word_w{1'b0}}, 8'h00, r_tag, 1'b1};
                    w_state_nxt = S_IDLE;
                end else if (!div_complete) begin
                    w_state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (div_complete) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_timeout) begin
                    w_push      = 1'b1;
                    w_push_data = {{c_word_w{1'b0}}, 8'h00, r_tag, 1'b1};
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Wait-cycle counter: cleared at launch, counts while waiting for complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_cnt <= '0;
        end else if ((r_state == S_WAIT_LO || r_state == S_WAIT_HI) && !w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Operand registers hold until the next accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_a   <= '0;
            r_div_b   <= '0;
            r_div_rnd <= '0;
            r_tag     <= '0;
        end else if (w_accept) begin
            r_div_a   <= in_a;
            r_div_b   <= in_b;
            r_div_rnd <= in_rnd;
            r_tag     <= in_tag;
        end
    end

    // Two-entry result FIFO; slot0 is always the head driving out_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_slot0 <= w_push_data;
                    else                 r_slot1 <= w_push_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_slot0 <= r_slot1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_slot0 <= w_push_data;
                    end else begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= w_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky status: a clear still keeps the bits of a same-cycle delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sticky <= 8'h00;
        else        r_sticky <= (clear_sticky ? 8'h00 : r_sticky) | (w_pop ? out_status : 8'h00);
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_div_seq_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_div_seq_issue
// Purpose  : Self-checking bench for fp_div_seq_issue with a behavioural
//            divider stub and a queue-based expected-result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_div_seq_issue;

    localparam int TOUT = 20;

    typedef struct packed {
        logic [31:0] z;
        logic [7:0]  st;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic [2:0]  in_rnd;
    logic [3:0]  in_tag;
    logic [31:0] div_a, div_b;
    logic [2:0]  div_rnd;
    logic        div_start;
    logic [31:0] div_z;
    logic [7:0]  div_status;
    logic        div_complete;
    logic        out_valid, out_ready;
    logic [31:0] out_z;
    logic [7:0]  out_status;
    logic [3:0]  out_tag;
    logic        out_err;
    logic [7:0]  sticky_status;
    logic        clear_sticky;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   cyc   = 0;
    int   n_start;
    logic prev_start;
    logic dbl_start;
    exp_t exp_q[$];
    logic [7:0] exp_sticky = 8'h00;
    bit   rand_rdy = 0;

    // divider stub controls: mode 0 normal, 1 stale complete, 2 hang
    int          dv_mode = 0;
    int          dv_lat  = 3;
    int          dv_cnt, dv_hold;
    logic        dv_busy;
    logic [31:0] dv_rz;
    logic [7:0]  dv_rs;

    fp_div_seq_issue #(.SIG_WIDTH(23), .EXP_WIDTH(8), .TAG_WIDTH(4), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_rnd(in_rnd), .in_tag(in_tag),
        .div_a(div_a), .div_b(div_b), .div_rnd(div_rnd), .div_start(div_start),
        .div_z(div_z), .div_status(div_status), .div_complete(div_complete),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_status(out_status), .out_tag(out_tag), .out_err(out_err),
        .sticky_status(sticky_status), .clear_sticky(clear_sticky)
    );

    always #5 clk = ~clk;

    // Divider result model: exact IEEE answers for the directed cases, a
    // distinctive operand hash otherwise (the controller only passes it on).
    function automatic logic [31:0] ref_z(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
        if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (b[30:0] == 31'h0) return {a[31] ^ b[31], 8'hFF, 23'h0};
        return a ^ {b[15:0], b[31:16]} ^ {29'h0, r};
    endfunction

    function automatic logic [7:0] ref_s(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
        if (a == 32'h40C00000 && b == 32'h40000000) return 8'h00;
        if (b[30:0] == 31'h0) return 8'h80;
        return (a[7:0] ^ b[15:8] ^ {5'h0, r}) & 8'h7F;
    endfunction

    // Divider stub: complete idles high, drops after start, rises after dv_lat.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_complete <= 1'b1;
            div_z        <= 32'h0;
            div_status   <= 8'h0;
            dv_busy      <= 1'b0;
            dv_cnt       <= 0;
            dv_hold      <= 0;
        end else if (div_start) begin
            dv_busy    <= 1'b1;
            dv_cnt     <= 0;
            dv_hold    <= (dv_mode == 1) ? 2 : 0;
            dv_rz      <= ref_z(div_a, div_b, div_rnd);
            dv_rs      <= ref_s(div_a, div_b, div_rnd);
            div_z      <= 32'hDEADBEEF;
            div_status <= 8'hA5;
            if (dv_mode != 1) div_complete <= 1'b0;
        end else if (dv_busy) begin
            if (dv_hold > 0) begin
                dv_hold <= dv_hold - 1;
                if (dv_hold == 1) div_complete <= 1'b0;
            end else if (dv_mode == 2) begin
                div_complete <= 1'b0;
            end else if (dv_cnt >= dv_lat) begin
                div_complete <= 1'b1;
                div_z        <= dv_rz;
                div_status   <= dv_rs;
                dv_busy      <= 1'b0;
            end else begin
                dv_cnt <= dv_cnt + 1;
            end
        end
    end

    // Launch pulse counter and back-to-back pulse detector.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_start    <= 0;
            prev_start <= 1'b0;
            dbl_start  <= 1'b0;
        end else begin
            prev_start <= div_start;
            if (div_start) n_start <= n_start + 1;
            if (div_start && prev_start) dbl_start <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle from negedge to negedge, scoring handshakes seen on the way.
    task automatic tick();
        logic acc, pp, clr;
        exp_t e;
        acc = in_valid && in_ready;
        pp  = out_valid && out_ready;
        clr = clear_sticky;
        e   = '0;
        if (pp) begin
            n_chk++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL phantom_pop: observed out_valid=1 tag=%0h expected no pending result", out_tag);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_z", 64'(out_z), 64'(e.z));
                chk("out_status", 64'(out_status), 64'(e.st));
                chk("out_tag", 64'(out_tag), 64'(e.tag));
                chk("out_err", 64'(out_err), 64'(e.err));
            end
        end
        if (acc) begin
            if (dv_mode == 2) exp_q.push_back('{z: 32'h0, st: 8'h0, tag: in_tag, err: 1'b1});
            else exp_q.push_back('{z: ref_z(in_a, in_b, in_rnd), st: ref_s(in_a, in_b, in_rnd), tag: in_tag, err: 1'b0});
        end
        exp_sticky = (clr ? 8'h00 : exp_sticky) | (pp ? e.st : 8'h00);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (acc) begin
            in_valid = 1'b0;
            n_acc++;
        end
        clear_sticky = 1'b0;
        if (pp || clr) chk("sticky_status", 64'(sticky_status), 64'(exp_sticky));
        if (rand_rdy) begin
            out_ready    = ($urandom_range(0, 1) == 1);
            clear_sticky = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r, input logic [3:0] t);
        int a0;
        bit done;
        a0 = n_acc;
        done = 0;
        in_a = a; in_b = b; in_rnd = r; in_tag = t; in_valid = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            tick();
            done = (n_acc != a0);
        end
        chk("accept", 64'(done), 64'd1);
        in_valid = 1'b0;
        if (done) begin
            chk("div_a_held", 64'(div_a), 64'(a));
            chk("div_b_held", 64'(div_b), 64'(b));
            chk("div_rnd_held", 64'(div_rnd), 64'(r));
        end
    endtask

    task automatic wait_out();
        for (int k = 0; k < 200 && !out_valid; k++) tick();
        chk("out_valid_wait", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 600 && (exp_q.size() != 0 || in_valid); k++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int s0, a0, t0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_rnd = '0; in_tag = '0;
        out_ready = 1'b0; clear_sticky = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_div_start", 64'(div_start), 64'd0);
        chk("rst_div_ab", 64'({div_a, div_b}), 64'd0);
        chk("rst_div_rnd", 64'(div_rnd), 64'd0);
        chk("rst_out_head", 64'({out_z, out_status, out_tag, out_err}), 64'd0);
        chk("rst_sticky", 64'(sticky_status), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // 6.0 / 2.0
        s0 = n_start;
        issue(32'h40C00000, 32'h40000000, 3'd0, 4'd3);
        wait_out();
        chk("one_start_pulse", 64'(n_start - s0), 64'd1);
        drain();

        // 1.0 / 0.0 and sticky behaviour
        issue(32'h3F800000, 32'h00000000, 3'd0, 4'd5);
        wait_out();
        drain();
        chk("sticky_dbz", 64'(sticky_status[7]), 64'd1);
        issue(32'h40C00000, 32'h40000000, 3'd0, 4'd6);
        drain();
        chk("sticky_holds", 64'(sticky_status[7]), 64'd1);
        clear_sticky = 1'b1;
        tick();
        chk("sticky_cleared", 64'(sticky_status), 64'd0);

        // Backpressure: third op must wait for a free slot
        out_ready = 1'b0;
        dv_lat = 3;
        s0 = n_start;
        issue(32'h12345678, 32'h0BADF00D, 3'd1, 4'd1);
        issue(32'h87654321, 32'h00C0FFEE, 3'd2, 4'd2);
        in_a = 32'h55AA55AA; in_b = 32'h13579BDF; in_rnd = 3'd3; in_tag = 4'd3; in_valid = 1'b1;
        a0 = n_acc;
        repeat (30) tick();
        chk("bp_starts", 64'(n_start - s0), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_no_accept", 64'(n_acc - a0), 64'd0);
        chk("bp_full_valid", 64'(out_valid), 64'd1);
        drain();
        chk("bp_all_starts", 64'(n_start - s0), 64'd3);

        // Stale complete held through launch and two cycles after
        dv_mode = 1; dv_lat = 2;
        issue(32'hCAFEBABE, 32'h01020304, 3'd4, 4'd9);
        wait_out();
        drain();
        dv_mode = 0;

        // Randomised traffic, mixing normal and stale completes
        rand_rdy = 1;
        for (int i = 0; i < 24; i++) begin
            dv_lat = $urandom_range(0, 8);
            issue($urandom, $urandom, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            dv_mode = $urandom_range(0, 1);
        end
        rand_rdy = 0;
        clear_sticky = 1'b0;
        drain();
        dv_mode = 0;

        // Timeout: divider never completes
        dv_mode = 2;
        out_ready = 1'b0;
        issue(32'h40C00000, 32'h40000000, 3'd0, 4'd12);
        t0 = cyc;
        wait_out();
        chk("timeout_elapsed_ge", 64'((cyc - t0) >= TOUT), 64'd1);
        chk("timeout_err_flag", 64'(out_err), 64'd1);
        drain();
        chk("timeout_idle_ready", 64'(in_ready), 64'd1);
        dv_mode = 0;

        // Reset during WAIT_HI with one result buffered
        out_ready = 1'b0;
        dv_lat = 2;
        issue(32'h11111111, 32'h22222222, 3'd0, 4'd7);
        wait_out();
        dv_lat = 12;
        issue(32'h33333333, 32'h44444444, 3'd0, 4'd8);
        repeat (4) tick();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        exp_sticky = 8'h00;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_div_a", 64'(div_a), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (20) tick();
        chk("postrst_no_phantom", 64'(out_valid), 64'd0);
        chk("postrst_in_ready", 64'(in_ready), 64'd1);
        dv_lat = 3;
        issue(32'h40C00000, 32'h40000000, 3'd0, 4'd4);
        drain();

        chk("no_double_start", 64'(dbl_start), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
